// File: rtl/knn_vote_selector.sv
// k-NN vote selector: keeps the K nearest (distance, type) samples of a query in a
// sorted register list, then runs a K-cycle majority vote and reports the winner.
module knn_vote_selector #(
    parameter int W = 8,
    parameter int K = 3,
    parameter int C = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [W-1:0]             distance,
    input  logic [W-1:0]             data_type,
    output logic                     busy,
    output logic                     result_valid,
    output logic [W-1:0]             result_type,
    output logic [$clog2(K+1)-1:0]   result_votes,
    output logic [W-1:0]             result_distance
);

    localparam int CW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_t;

    state_t                  state_q;
    logic [K-1:0]            vld_q, vld_d;
    logic [K-1:0][W-1:0]     dist_q, dist_d;
    logic [K-1:0][W-1:0]     type_q, type_d;
    logic [C-1:0][CW-1:0]    cnt_q;
    logic [C-1:0][IW-1:0]    first_q;
    logic [IW-1:0]           vidx_q;
    logic [K-1:0]            le;

    logic [W-1:0]            win_type;
    logic [CW-1:0]           win_cnt;
    logic [IW-1:0]           win_first;

    assign in_ready = (state_q == COLLECT);
    assign busy     = (state_q != IDLE);

    // le[j]: entry j stays put. Valid entries form a sorted prefix, so le is a
    // prefix too; "<=" puts a new sample after existing equal distances.
    always_comb begin
        vld_d  = vld_q;
        dist_d = dist_q;
        type_d = type_q;
        le     = '0;
        for (int j = 0; j < K; j++)
            le[j] = vld_q[j] && (dist_q[j] <= distance);
        if (!le[0]) begin
            vld_d[0]  = 1'b1;
            dist_d[0] = distance;
            type_d[0] = data_type;
        end
        for (int j = 1; j < K; j++) begin
            if (!le[j]) begin
                if (le[j-1]) begin
                    vld_d[j]  = 1'b1;
                    dist_d[j] = distance;
                    type_d[j] = data_type;
                end else begin
                    vld_d[j]  = vld_q[j-1];
                    dist_d[j] = dist_q[j-1];
                    type_d[j] = type_q[j-1];
                end
            end
        end
    end

    // Highest count wins; equal counts go to the class seen first in the list.
    always_comb begin
        win_type  = '0;
        win_cnt   = '0;
        win_first = '1;
        for (int c = 0; c < C; c++) begin
            if ((cnt_q[c] > win_cnt) ||
                ((cnt_q[c] != '0) && (cnt_q[c] == win_cnt) && (first_q[c] < win_first))) begin
                win_type  = W'(c);
                win_cnt   = cnt_q[c];
                win_first = first_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            vld_q           <= '0;
            dist_q          <= '1;
            type_q          <= '0;
            cnt_q           <= '0;
            first_q         <= '0;
            vidx_q          <= '0;
            result_valid    <= 1'b0;
            result_type     <= '0;
            result_votes    <= '0;
            result_distance <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vld_q   <= '0;
                        dist_q  <= '1;
                        type_q  <= '0;
                        cnt_q   <= '0;
                        first_q <= '0;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        vld_q  <= vld_d;
                        dist_q <= dist_d;
                        type_q <= type_d;
                        if (in_last) begin
                            vidx_q  <= '0;
                            state_q <= VOTE;
                        end
                    end
                end
                VOTE: begin
                    // Only labels 0..C-1 can match a class, so out-of-range types never count.
                    for (int c = 0; c < C; c++) begin
                        if (vld_q[vidx_q] && (type_q[vidx_q] == W'(c))) begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
                            if (cnt_q[c] == '0)
                                first_q[c] <= vidx_q;
                        end
                    end
                    vidx_q <= vidx_q + 1'b1;
                    if (vidx_q == IW'(K - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    result_type     <= win_type;
                    result_votes    <= win_cnt;
                    result_distance <= dist_q[0];
                    result_valid    <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote_selector.sv
// Directed bench for knn_vote_selector: stimulus pushes expected results into a
// scoreboard queue; a monitor pops and checks each result_valid pulse and its latency.
module tb_knn_vote_selector;

    localparam int W  = 8;
    localparam int K  = 3;
    localparam int C  = 4;
    localparam int VW = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [W-1:0]  distance = '0;
    logic [W-1:0]  data_type = '0;
    logic          busy;
    logic          result_valid;
    logic [W-1:0]  result_type;
    logic [VW-1:0] result_votes;
    logic [W-1:0]  result_distance;

    knn_vote_selector #(.W(W), .K(K), .C(C)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .distance(distance), .data_type(data_type), .busy(busy),
        .result_valid(result_valid), .result_type(result_type),
        .result_votes(result_votes), .result_distance(result_distance)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int v;
        int d;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the head of the scoreboard, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && result_valid) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got result_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("result_type", int'(result_type), e.t);
                    chk("result_votes", int'(result_votes), e.v);
                    chk("result_distance", int'(result_distance), e.d);
                    chk("result_latency", cyc, e.due);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                e = sbq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL result_timeout: got no result by cycle %0d, expected at %0d", cyc, e.due);
            end
        end
    end

    task automatic start_q();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input int d, input int t, input bit last, input int gap);
        int g;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid  = 1'b1;
        distance  = W'(d);
        data_type = W'(t);
        in_last   = last;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 (cycle %0d)", cyc);
        end
        last_cyc = cyc;
        @(posedge clk);
        #1;
        // Garbage on the data lines while idle must never be absorbed.
        in_valid  = 1'b0;
        in_last   = 1'b0;
        distance  = '0;
        data_type = W'(3);
    endtask

    task automatic push(input int t, input int v, input int d);
        exp_t e;
        e.t = t;
        e.v = v;
        e.d = d;
        e.due = last_cyc + K + 2;
        sbq.push_back(e);
    endtask

    task automatic wait_rv();
        int g;
        g = 0;
        @(negedge clk);
        while (!result_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!result_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_result: got result_valid=0, expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sbq.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_result_type"}, int'(result_type), 0);
        chk({tag, "_result_votes"}, int'(result_votes), 0);
        chk({tag, "_result_distance"}, int'(result_distance), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("reset");

        // Basic query with gaps; 30 is discarded once the list is full
        start_q();
        send(20, 1, 1'b0, 0);
        send(5, 2, 1'b0, 2);
        send(9, 2, 1'b0, 0);
        send(30, 1, 1'b0, 1);
        send(7, 0, 1'b1, 0);
        push(2, 2, 5);
        // Hold start through VOTE/DONE: it must be ignored
        start = 1'b1;
        for (int i = 0; i < K + 1; i++) begin
            @(negedge clk);
            chk("vote_in_ready_low", int'(in_ready), 0);
            chk("vote_busy_high", int'(busy), 1);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("start_ignored_busy", int'(busy), 0);

        // Equal distances: stable order keeps 1,2,3; tie goes to type 1
        start_q();
        send(10, 1, 1'b0, 0);
        send(10, 2, 1'b0, 0);
        send(10, 3, 1'b0, 0);
        send(10, 0, 1'b1, 0);
        push(1, 1, 10);

        // Back-to-back start in the result_valid cycle
        wait_rv();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        send(12, 2, 1'b1, 0);
        push(2, 1, 12);
        wait_rv();

        // Lone out-of-range type: no votes, distance still reported
        start_q();
        send(40, 7, 1'b1, 0);
        push(0, 0, 40);
        wait_drain();

        // Reset in the middle of a query
        start_q();
        send(1, 2, 1'b0, 0);
        send(2, 2, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("midreset");

        start_q();
        send(3, 1, 1'b0, 0);
        send(4, 1, 1'b1, 0);
        push(1, 2, 3);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
